// File: rtl/synchronous_fifo_pkg.sv
// Shared constants, pointer/flag helpers and error-bit positions for synchronous_fifo.
// Pointers carry one extra wrap bit above the storage index.
package synchronous_fifo_pkg;

  typedef enum int unsigned {
    ERR_OVERFLOW  = 0,
    ERR_UNDERFLOW = 1
  } err_bit_e;

  localparam int ERR_BITS = 2;

  typedef struct packed {
    logic full;
    logic empty;
  } flags_t;

  function automatic int ptr_width(input int abl);
    return abl + 1;
  endfunction

  function automatic int depth_of(input int abl);
    return 1 << abl;
  endfunction

  // Pointers arrive zero-extended to 32 bits; bit abl is the wrap bit.
  function automatic flags_t decode_flags(input logic [31:0] wptr, input logic [31:0] rptr,
                                          input int abl);
    logic [31:0] diff;
    logic [31:0] low_mask;
    flags_t      f;
    diff     = wptr ^ rptr;
    low_mask = (32'd1 << abl) - 32'd1;
    f.empty  = (diff == 32'd0);
    f.full   = ((diff & low_mask) == 32'd0) && diff[abl];
    return f;
  endfunction

endpackage

// File: rtl/synchronous_fifo_regfile.sv
// Storage array for synchronous_fifo: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_regfile #(
  parameter int address_bus_length = 4,
  parameter int data_bus_length    = 8
) (
  input  logic                          clk,
  input  logic                          write_en,
  input  logic [address_bus_length-1:0] write_addr,
  input  logic [data_bus_length-1:0]    write_data,
  input  logic [address_bus_length-1:0] read_addr,
  output logic [data_bus_length-1:0]    read_data
);

  logic [data_bus_length-1:0] mem [0:(1<<address_bus_length)-1];

  always_ff @(posedge clk) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  assign read_data = mem[read_addr];

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with fill level, thresholds, sticky errors and synchronous flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module synchronous_fifo
  import synchronous_fifo_pkg::*;
#(
  parameter int address_bus_length  = 4,
  parameter int data_bus_length     = 8,
  parameter int almost_full_margin  = 2,
  parameter int almost_empty_margin = 2
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          write_enable,
  input  logic [data_bus_length-1:0]    trans_data,
  input  logic                          read_enable,
  output logic [data_bus_length-1:0]    recv_data,
  output logic                          recv_valid,
  input  logic                          fifo_flush,
  input  logic                          clear_errors,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [address_bus_length:0]   fifo_count,
  output logic                          overflow_err,
  output logic                          underflow_err
);

  localparam int ptr_w      = ptr_width(address_bus_length);
  localparam int fifo_depth = depth_of(address_bus_length);
  localparam logic [ptr_w-1:0] af_level = ptr_w'(fifo_depth - almost_full_margin);
  localparam logic [ptr_w-1:0] ae_level = ptr_w'(almost_empty_margin);

  logic [ptr_w-1:0]           wptr;
  logic [ptr_w-1:0]           rptr;
  logic [ERR_BITS-1:0]        err;
  logic [data_bus_length-1:0] read_word;
  flags_t                     flags;
  logic                       push_ok;
  logic                       pop_ok;

  assign flags        = decode_flags(32'(wptr), 32'(rptr), address_bus_length);
  assign fifo_full    = flags.full;
  assign fifo_empty   = flags.empty;
  assign fifo_count   = wptr - rptr;
  assign almost_full  = (fifo_count >= af_level);
  assign almost_empty = (fifo_count <= ae_level);
  assign push_ok      = write_enable & ~fifo_full;
  assign pop_ok       = read_enable & ~fifo_empty;

  fifo_regfile #(
    .address_bus_length(address_bus_length),
    .data_bus_length   (data_bus_length)
  ) u_regfile (
    .clk       (sys_clk),
    .write_en  (push_ok & ~fifo_flush),
    .write_addr(wptr[address_bus_length-1:0]),
    .write_data(trans_data),
    .read_addr (rptr[address_bus_length-1:0]),
    .read_data (read_word)
  );

  // Flush overrides any push or pop in the same cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (fifo_flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ptr_w'(1);
      if (pop_ok)  rptr <= rptr + ptr_w'(1);
    end
  end

  // clear_errors wins over a same-cycle error event; flush cycles never raise errors.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err <= '0;
    end else if (clear_errors) begin
      err <= '0;
    end else if (!fifo_flush) begin
      if (write_enable & fifo_full)  err[ERR_OVERFLOW]  <= 1'b1;
      if (read_enable & fifo_empty)  err[ERR_UNDERFLOW] <= 1'b1;
    end
  end

  assign overflow_err  = err[ERR_OVERFLOW];
  assign underflow_err = err[ERR_UNDERFLOW];

`ifdef SYNC_FIFO_FWFT_EN
  assign recv_data  = read_word;
  assign recv_valid = ~fifo_empty;
`else
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      recv_data  <= '0;
      recv_valid <= 1'b0;
    end else begin
      recv_valid <= pop_ok & ~fifo_flush;
      if (pop_ok & ~fifo_flush) recv_data <= read_word;
    end
  end
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Scoreboard bench for synchronous_fifo: stimulus queues expected words, a negedge monitor checks them.
// Works with or without SYNC_FIFO_FWFT_EN.
module tb_synchronous_fifo;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       write_enable = 1'b0;
  logic [7:0] trans_data = 8'h00;
  logic       read_enable = 1'b0;
  logic [7:0] recv_data;
  logic       recv_valid;
  logic       fifo_flush = 1'b0;
  logic       clear_errors = 1'b0;
  logic       fifo_full, fifo_empty, almost_full, almost_empty;
  logic [4:0] fifo_count;
  logic       overflow_err, underflow_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         model_count = 0;
  bit         m_ovf = 0;
  bit         m_unf = 0;
  bit         last_pop = 0;

  synchronous_fifo dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .write_enable (write_enable),
    .trans_data   (trans_data),
    .read_enable  (read_enable),
    .recv_data    (recv_data),
    .recv_valid   (recv_valid),
    .fifo_flush   (fifo_flush),
    .clear_errors (clear_errors),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".count"},         32'(fifo_count),    32'(model_count));
    check({tag, ".full"},          32'(fifo_full),     32'(model_count == 16));
    check({tag, ".empty"},         32'(fifo_empty),    32'(model_count == 0));
    check({tag, ".almost_full"},   32'(almost_full),   32'(model_count >= 14));
    check({tag, ".almost_empty"},  32'(almost_empty),  32'(model_count <= 2));
    check({tag, ".overflow_err"},  32'(overflow_err),  32'(m_ovf));
    check({tag, ".underflow_err"}, 32'(underflow_err), 32'(m_unf));
  endtask

  // One clock of stimulus; the reference model advances just after the edge.
  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic re,
                               input logic fl, input logic clr);
    bit push_ok;
    bit pop_ok;
    write_enable = we;
    trans_data   = data;
    read_enable  = re;
    fifo_flush   = fl;
    clear_errors = clr;
    push_ok = we && (model_count < 16);
    pop_ok  = re && (model_count > 0);
    @(posedge sys_clk);
    #1;
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end else if (!fl) begin
      if (we && model_count == 16) m_ovf = 1;
      if (re && model_count == 0)  m_unf = 1;
    end
    if (fl) begin
      for (int i = 0; i < model_count; i++) void'(exp_q.pop_back());
      model_count = 0;
      last_pop = 0;
    end else begin
      if (push_ok) exp_q.push_back(data);
      last_pop = pop_ok;
      model_count = model_count + int'(push_ok) - int'(pop_ok);
    end
    write_enable = 1'b0;
    read_enable  = 1'b0;
    fifo_flush   = 1'b0;
    clear_errors = 1'b0;
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  always @(negedge sys_clk) begin
    check("mon.recv_valid", 32'(recv_valid), 32'(model_count != 0));
    if (recv_valid && read_enable && !fifo_flush && !sys_rst) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL mon.unexpected_word actual=%0h required=none", recv_data);
      end else check("mon.recv_data", 32'(recv_data), 32'(exp_q.pop_front()));
    end
  end
`else
  always @(negedge sys_clk) begin
    check("mon.recv_valid", 32'(recv_valid), 32'(last_pop));
    if (recv_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL mon.unexpected_word actual=%0h required=none", recv_data);
      end else check("mon.recv_data", 32'(recv_data), 32'(exp_q.pop_front()));
    end
  end
`endif

  initial begin
    #2;
    checkOutput("reset");
`ifndef SYNC_FIFO_FWFT_EN
    check("reset.recv_data", 32'(recv_data), 32'h0);
`endif
    check("reset.recv_valid", 32'(recv_valid), 32'h0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Fill to full with 0x00..0x0F.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill");
    end

    // Overflow attempt, then drain in order.
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkOutput("drain");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Underflow, then clear both sticky errors.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("underflow");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("clear");

    // Steady state at count 5 with simultaneous push/pop; pointers wrap past 31.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("steady");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Count 9, then flush with a competing write.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_flush");
    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    checkOutput("flush");
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush");

    // Asynchronous reset mid-burst at count 7.
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset");
    #2;
    sys_rst = 1'b1;
    for (int i = 0; i < model_count; i++) void'(exp_q.pop_back());
    model_count = 0; m_ovf = 0; m_unf = 0; last_pop = 0;
    #1;
    checkOutput("async_reset");
    check("async_reset.recv_valid", 32'(recv_valid), 32'h0);
`ifndef SYNC_FIFO_FWFT_EN
    check("async_reset.recv_data", 32'(recv_data), 32'h0);
`endif
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // Single push after reset; visible immediately only in fall-through mode.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft.recv_valid", 32'(recv_valid), 32'h1);
    check("fwft.recv_data", 32'(recv_data), 32'h0);
`else
    check("first_push.recv_valid", 32'(recv_valid), 32'h0);
`endif
    checkOutput("first_push");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("final");
    check("final.scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synchronous_fifo.md
Name: synchronous_fifo

Overview:
- Single-clock, parametrised FIFO. It is the single-domain successor to the team's dual-clock FIFO and keeps the same data/flag port naming.
- Adds features the dual-clock FIFO lacks: fill level, almost-full/almost-empty thresholds, sticky overflow/underflow errors, synchronous flush, and a registered read-data path.
- Sits inside one clock domain, between a producer and a consumer that both run on sys_clk.

Parameters:
- address_bus_length, 4, log2 of storage depth; fifo_depth = 2**address_bus_length (derived, not overridable).
- data_bus_length, 8, data word width.
- almost_full_margin, 2, almost_full asserts when free slots <= this; legal range 1..fifo_depth-1.
- almost_empty_margin, 2, almost_empty asserts when fill <= this; legal range 1..fifo_depth-1.

Ports:
- sys_clk  in  1  single clock; all state updates on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- write_enable  in  1  push request.
- trans_data  in  data_bus_length  push data.
- read_enable  in  1  pop request.
- recv_data  out  data_bus_length  pop data.
- recv_valid  out  1  recv_data holds a newly popped word.
- fifo_flush  in  1  synchronous empty-the-queue.
- clear_errors  in  1  synchronous clear of sticky errors.
- fifo_full, fifo_empty, almost_full, almost_empty  out  1 each  status flags.
- fifo_count  out  address_bus_length+1  current fill level, 0..fifo_depth.
- overflow_err, underflow_err  out  1 each  sticky error flags.

Behaviour:
- Pointers:
  - wptr and rptr are (address_bus_length+1)-bit binary; the MSB is the wrap bit, and the low bits index storage.
  - Both wrap modulo 2**(address_bus_length+1).
- Flags and count:
  - fifo_count = wptr - rptr, modulo pointer width.
  - fifo_full when the low bits are equal and the MSBs differ.
  - fifo_empty when the full pointers are equal.
  - almost_full = (fifo_count >= fifo_depth - almost_full_margin).
  - almost_empty = (fifo_count <= almost_empty_margin).
  - All flags are decoded from registered pointers, so they reflect an accepted push or pop on the cycle after the edge that accepted it.
- Accept rules:
  - Push is accepted iff write_enable & ~fifo_full.
  - Pop is accepted iff read_enable & ~fifo_empty.
  - Push and pop accepted in the same cycle: count is unchanged.
  - When full with both requested: only the pop is accepted. No write-through on full.
  - When empty with both requested: only the push is accepted. No read-through on empty.
- Read path (default):
  - On an accepted pop, recv_data <= mem[rptr] at that edge, and recv_valid pulses high for exactly one cycle. Read latency is one cycle.
  - recv_data holds its last value otherwise; recv_valid is 0 otherwise.
- Errors:
  - overflow_err is set on write_enable & fifo_full.
  - underflow_err is set on read_enable & fifo_empty.
  - Both are sticky until clear_errors or reset.
  - clear_errors has priority over a same-cycle set: it clears, and a same-cycle error event is lost.
- Flush:
  - fifo_flush sets wptr = rptr = 0 and overrides any same-cycle push or pop; no error flag is set that cycle.
  - recv_data is kept; recv_valid = 0.
  - Storage contents are not cleared.
- Reset (sys_rst high, asynchronous, any time including mid-transfer):
  - wptr = rptr = 0, recv_data = 0, recv_valid = 0, overflow_err = underflow_err = 0.
  - Hence fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0, fifo_count = 0.
  - Storage array is not reset.
- Ordering is strict FIFO. A word pushed at edge N is poppable at edge N+1.

Optional Feature:
- Macro name: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through mode):
  - recv_data = mem[rptr] combinationally, and recv_valid = ~fifo_empty.
  - read_enable acknowledges the displayed word and advances rptr.
  - A word pushed at edge N is visible on recv_data after edge N.
  - Reset values of recv_valid and flags are unchanged; recv_data shows mem[0] after reset (don't-care while recv_valid = 0).
- Not defined: the registered one-cycle read path described under Behaviour.

Decomposition:
- Shared package synchronous_fifo_pkg:
  - pointer-width constant function (address_bus_length+1);
  - fifo_depth derivation;
  - flag-decode function (full/empty from pointers);
  - error-flag enum/bit positions.
- One sub-module, fifo_regfile: a dual-port register array with one synchronous write port and one asynchronous read port, parametrised on address_bus_length and data_bus_length. The top level holds pointers, flags, errors and the read register.

Test Plan:
1. Reset then 16 pushes of 0x00..0x0F with no reads -> fifo_full = 1 after the 16th edge; almost_full first asserts after the 14th push (count = 14); fifo_count = 16.
2. From full, push 0xAA -> overflow_err = 1, count stays 16. Then 16 pops -> recv_data sequence 0x00..0x0F, each one cycle after its pop; fifo_empty = 1; 0xAA never appears.
3. From empty, assert read_enable -> underflow_err = 1, recv_valid stays 0. Pulse clear_errors -> underflow_err = 0 next cycle.
4. At count = 5, push and pop held together for 20 cycles -> fifo_count stays 5 throughout; output data in push order; pointers wrap past 31 with no glitch on the flags.
5. At count = 9, assert fifo_flush together with write_enable -> next cycle count = 0, fifo_empty = 1, no write retained, errors unchanged.
6. Assert sys_rst asynchronously mid-burst (count = 7, between edges) -> all outputs take reset values immediately, without waiting for a clock edge. Repeat test 1 with SYNC_FIFO_FWFT_EN defined -> 0x00 is on recv_data with recv_valid = 1 one edge after the first push.
